gray_rx: RTL and testbench

Receiving end of the Gray-code counter link: samples a WIDTH-bit Gray-coded word, decodes it to binary, and checks that successive samples move by exactly one code step. It sits downstream of the Gray counter, typically across a domain crossing or a long route where only single-bit transitions are legal. It reports the decoded value, the count direction, a lock indication and a saturating error count.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_rx.sv | 120 ++++++++++++
 tb/tb_gray_rx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code link definitions: receiver state encoding and the
// Gray/binary conversion helpers used by both ends of the link.
package gray_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } rx_state_e;

  // Prefix-XOR decode; zero-extended narrower words decode correctly.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_rx.sv
// Gray-code link receiver: decodes each accepted sample, tracks lock on
// single-step motion and counts illegal steps (saturating).
module gray_rx
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             dir,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             locked_q, locked_d;
  logic             dir_q, dir_d;
  logic             step_err_q, step_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [MAX_W-1:0] gray_ext_s;
  logic [MAX_W-1:0] bin_ext_s;
  logic [WIDTH-1:0] bin_new_s;
  logic [WIDTH-1:0] delta_s;
  logic             step_up_s;
  logic             step_dn_s;
  logic             step_hold_s;

  assign gray_ext_s  = MAX_W'(gray_in);
  assign bin_ext_s   = gray2bin(gray_ext_s);
  assign bin_new_s   = bin_ext_s[WIDTH-1:0];
  // Modular difference: wrap-around steps look like ordinary +1 / -1.
  assign delta_s     = bin_new_s - ref_q;
  assign step_up_s   = (delta_s == WIDTH'(1));
  assign step_dn_s   = (delta_s == {WIDTH{1'b1}});
  assign step_hold_s = (delta_s == {WIDTH{1'b0}});

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    dir_d       = dir_q;
    step_err_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (valid_in) begin
      ref_d       = bin_new_s;
      bin_d       = bin_new_s;
      bin_valid_d = 1'b1;
      case (state_q)
        IDLE: state_d = ACQ;
        ACQ: begin
          if (step_up_s || step_dn_s) begin
            dir_d   = step_up_s;
            state_d = LOCK;
          end else begin
            state_d = ACQ;
          end
        end
        LOCK: begin
          if (step_up_s || step_dn_s) begin
            dir_d = step_up_s;
          end else if (step_hold_s) begin
            state_d = LOCK;
          end else begin
            step_err_d = 1'b1;
            state_d    = ACQ;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ref_q       <= {WIDTH{1'b0}};
      bin_q       <= {WIDTH{1'b0}};
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      dir_q       <= 1'b1;
      step_err_q  <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      locked_q    <= locked_d;
      dir_q       <= dir_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_valid_q;
  assign locked    = locked_q;
  assign dir       = dir_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_rx.sv
// Scoreboard bench for gray_rx: directed samples push hand-computed
// expectations; a negedge monitor pops them on every bin_valid pulse.
module tb_gray_rx;

  typedef struct {
    logic [3:0] bin;
    logic       locked;
    logic       dir;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] gray_in;
  logic       valid_in;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       locked;
  logic       dir;
  logic       step_err;
  logic [7:0] err_cnt;

  int   checks;
  int   failures;
  int   sent;
  int   pulses;
  exp_t exp_q[$];

  gray_rx #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .gray_in  (gray_in),
    .valid_in (valid_in),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .locked   (locked),
    .dir      (dir),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [3:0] g, input logic [3:0] b, input logic lk,
                      input logic d, input logic e, input logic [7:0] c);
    exp_t x;
    x.bin = b; x.locked = lk; x.dir = d; x.err = e; x.cnt = c;
    exp_q.push_back(x);
    sent++;
    gray_in  = g;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    valid_in = 1'b0;
    gray_in  = 4'hA;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bin_out"},   32'(bin_out),   32'd0);
    chk({tag, "_bin_valid"}, 32'(bin_valid), 32'd0);
    chk({tag, "_locked"},    32'(locked),    32'd0);
    chk({tag, "_dir"},       32'(dir),       32'd1);
    chk({tag, "_step_err"},  32'(step_err),  32'd0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bin_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bin_valid actual=1 required=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("bin_out",  32'(bin_out),  32'(e.bin));
        chk("locked",   32'(locked),   32'(e.locked));
        chk("dir",      32'(dir),      32'(e.dir));
        chk("step_err", 32'(step_err), 32'(e.err));
        chk("err_cnt",  32'(err_cnt),  32'(e.cnt));
      end
    end else if (step_err !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL step_err_without_valid actual=%b required=0 at %0t", step_err, $time);
    end
  end

  logic [3:0] up_gray [10];
  logic [7:0] cnt;

  initial begin
    checks   = 0;
    failures = 0;
    sent     = 0;
    pulses   = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    gray_in  = 4'd0;
    up_gray  = '{4'd5, 4'd4, 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Basic count up: acquire on first sample, lock on second.
    send(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    send(4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd3, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd6, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd7, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0);

    // Climb to all-ones, then wrap forwards and backwards.
    for (int i = 0; i < 10; i++) begin
      send(up_gray[i], 4'(6 + i), 1'b1, 1'b1, 1'b0, 8'd0);
    end
    send(4'd0, 4'd0,  1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd8, 4'd15, 1'b1, 1'b0, 1'b0, 8'd0);
    send(4'd0, 4'd0,  1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd1, 4'd1,  1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd3, 4'd2,  1'b1, 1'b1, 1'b0, 8'd0);
    send(4'd2, 4'd3,  1'b1, 1'b1, 1'b0, 8'd0);

    // Skip 3 -> 5 while locked, then relock on 6.
    send(4'd7, 4'd5, 1'b0, 1'b1, 1'b1, 8'd1);
    send(4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 8'd1);

    // Walk down to 2, then hold with idle gaps.
    send(4'd7, 4'd5, 1'b1, 1'b0, 1'b0, 8'd1);
    send(4'd6, 4'd4, 1'b1, 1'b0, 1'b0, 8'd1);
    send(4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 8'd1);
    send(4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 8'd1);
    gap(3);
    chk("gap_bin_out",   32'(bin_out),   32'd2);
    chk("gap_bin_valid", 32'(bin_valid), 32'd0);
    chk("gap_locked",    32'(locked),    32'd1);
    chk("gap_err_cnt",   32'(err_cnt),   32'd1);
    send(4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 8'd1);
    gap(2);
    send(4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 8'd1);

    // Saturation: two illegal steps per four-sample loop, 260 in total.
    cnt = 8'd1;
    for (int k = 0; k < 130; k++) begin
      cnt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
      send(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, cnt);
      send(4'd1, 4'd1, 1'b1, 1'b1, 1'b0, cnt);
      cnt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
      send(4'd2, 4'd3, 1'b0, 1'b1, 1'b1, cnt);
      send(4'd3, 4'd2, 1'b1, 1'b0, 1'b0, cnt);
    end
    gap(1);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    chk("sat_locked",  32'(locked),  32'd1);

    // Reset while locked with a sample present: sample is dropped.
    reset    = 1'b1;
    valid_in = 1'b1;
    gray_in  = 4'd2;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    chk_reset_vals("midreset");
    send(4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    send(4'd3, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    gap(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pulse_count",   32'(pulses),       32'(sent));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
